// File: rtl/hil_pkg.sv
// Shared definitions for the HIL result return path: transmitter states,
// result-byte layout and the packing helper used by the top level.
package hil_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int MISMATCH = 7;
    localparam int OBS_Y    = 6;
    localparam int SEL_HI   = 5;
    localparam int SEL_LO   = 4;

    // 100 MHz system clock at 115200 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    // Builds the result byte from one observation; bit 7 flags y != i[s].
    function automatic logic [7:0] pack_result(input logic [3:0] i,
                                               input logic [1:0] s,
                                               input logic       y);
        logic [7:0] r;
        r                = {4'b0000, i};
        r[SEL_HI:SEL_LO] = s;
        r[OBS_Y]         = y;
        r[MISMATCH]      = (y != i[s]);
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// UART 8N1 transmitter with a byte-wide valid/ready input. The line output is
// registered; ready/busy decode the state directly and are forced low in reset.
module uart_tx_core
    import hil_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       tx,
    output logic       busy
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    tx_state_t   state, state_next;
    logic [15:0] baud, baud_next;
    logic [2:0]  bit_idx, bit_idx_next;
    logic [7:0]  shift, shift_next;
    logic        tx_next;
    logic        bit_done;

    assign bit_done = (baud == BAUD_LAST);
    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE) && !rst;

    always_comb begin
        // NOTE: every next-state signal gets a default before the case so no
        // path through this block can leave one unassigned and infer a latch.
        state_next   = state;
        baud_next    = baud;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        tx_next      = tx;

        case (state)
            IDLE: begin
                tx_next      = 1'b1;
                baud_next    = '0;
                bit_idx_next = '0;
                if (in_valid && in_ready) begin
                    shift_next = in_data;
                    tx_next    = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                if (bit_done) begin
                    baud_next  = '0;
                    tx_next    = shift[0];
                    state_next = DATA;
                end else begin
                    baud_next = baud + 16'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        // Shift first so tx always shows shift[0] during a bit.
                        bit_idx_next = bit_idx + 3'd1;
                        shift_next   = {1'b0, shift[7:1]};
                        tx_next      = shift[1];
                    end
                end else begin
                    baud_next = baud + 16'd1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    baud_next  = '0;
                    state_next = IDLE;
                end else begin
                    baud_next = baud + 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
                baud_next  = '0;
                tx_next    = 1'b1;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_next;
            baud    <= baud_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            tx      <= tx_next;
        end
    end

endmodule

// File: rtl/hil_result_tx.sv
// HIL return path: checks one 4:1 mux observation, packs the verdict into a
// result byte for the UART and keeps saturating pass/fail counters.
module hil_result_tx
    import hil_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cap_valid,
    output logic       cap_ready,
    input  logic [3:0] cap_i,
    input  logic [1:0] cap_s,
    input  logic       cap_y,
    output logic       tx,
    output logic       busy,
    output logic [7:0] pass_cnt,
    output logic [7:0] fail_cnt
);

    logic [7:0] result;
    logic       accept;

    assign result = pack_result(cap_i, cap_s, cap_y);
    assign accept = cap_valid && cap_ready;

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .in_valid(cap_valid),
        .in_ready(cap_ready),
        .in_data (result),
        .tx      (tx),
        .busy    (busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (accept) begin
            if (result[MISMATCH]) begin
                if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
            end else begin
                if (pass_cnt != 8'hFF) pass_cnt <= pass_cnt + 8'd1;
            end
        end
    end

endmodule

// File: doc/hil_result_tx.md
# hil_result_tx

- Return-path block of the RPi-FPGA HIL verifier: captures one DUT observation (stimulus `I`/`S` plus observed mux output `Y`) and checks it against the expected 4:1 mux result `I[S]`.
- Packs stimulus, observation and verdict into one result byte and sends it to the Raspberry Pi on a UART 8N1 line.
- Keeps saturating pass/fail counters, so the Pi side and the on-board debug both see the verdict stream.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200); legal range 4..65535.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `cap_valid`  in  1  capture request; one observation presented.
- `cap_ready`  out  1  block can accept; transfer occurs when `cap_valid && cap_ready`.
- `cap_i`  in  4  stimulus data inputs `I` applied to the DUT.
- `cap_s`  in  2  stimulus select `S` applied to the DUT.
- `cap_y`  in  1  observed DUT output `Y`.
- `tx`  out  1  UART serial output; idle high.
- `busy`  out  1  frame in progress; equals `!cap_ready` outside reset.
- `pass_cnt`  out  8  count of matching observations; saturates at 255.
- `fail_cnt`  out  8  count of mismatching observations; saturates at 255.

## Operation
- Result byte, latched on accept:
  - bit7 = mismatch (`cap_y != cap_i[cap_s]`)
  - bit6 = `cap_y`
  - bits5:4 = `cap_s`
  - bits3:0 = `cap_i`
- Inputs are sampled only on the accept cycle; later changes do not affect the frame in flight.
- On accept, exactly one of `pass_cnt`/`fail_cnt` increments by 1. The increment is skipped if that counter is already 255; there is no wrap.
- UART frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- FSM states:
  - IDLE: `tx`=1, `cap_ready`=1. Goes to START on accept.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: bit index 0..7, each held CLKS_PER_BIT cycles. After bit 7, goes to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles, then IDLE.
- Baud counter runs 0..CLKS_PER_BIT-1 and reloads to 0 on each bit boundary. Bit index is 3 bits and terminates at 7, not by overflow.
- `cap_valid` while busy is ignored: nothing is queued and counters do not change.
- Reset values, and values for every cycle `rst` is high:
  - `tx`=1, `cap_ready`=0, `busy`=0, `pass_cnt`=0, `fail_cnt`=0
  - FSM in IDLE, baud counter 0
- Reset mid-frame aborts the frame. `tx` is 1 on the first cycle after the reset edge, and no partial frame resumes.

## Timing
- Accept on cycle N:
  - `tx` falls at N+1.
  - Counter update is visible at N+1.
  - `cap_ready` drops at N+1.
- Data bit k is driven on `tx` from N+1+(k+1)·CLKS_PER_BIT for CLKS_PER_BIT cycles.
- Stop bit ends and `cap_ready` returns high at N+1+10·CLKS_PER_BIT. Back-to-back accept is possible on that cycle, so the frame period is 10·CLKS_PER_BIT+1 cycles.
- `cap_ready` rises on the first cycle after `rst` deasserts.
- All outputs are registered except `cap_ready`/`busy`, which decode the FSM state directly; `rst` gates `cap_ready` low.

## Structure
- Shared package `hil_pkg`:
  - FSM state enum (IDLE, START, DATA, STOP)
  - result-byte bit positions (MISMATCH=7, OBS_Y=6, SEL_HI=5, SEL_LO=4)
  - default CLKS_PER_BIT constant
- Sub-module `uart_tx_core`: byte-in/valid-ready, baud counter, shift register, FSM, `tx`.
- Top `hil_result_tx` holds the mux reference model, byte packing and saturating counters.

## Test plan
All scenarios run with CLKS_PER_BIT=4.
- I=1010, S=00, Y=0, one accept -> byte 0x0A; `tx` sequence 0,0,1,0,1,0,0,0,0,1 (4 cycles each); `pass_cnt`=1, `fail_cnt`=0.
- I=1010, S=01, Y=0 -> mismatch, byte 0x9A; `fail_cnt`=1; `pass_cnt` unchanged.
- Hold `cap_valid` high and sweep S=00..11 with Y=I[S] for I=1010 -> bytes 0x0A, 0x5A, 0x2A, 0x7A in order:
  - each accept 41 cycles apart
  - no dropped or duplicated frame
  - `pass_cnt`=4
- Pulse `cap_valid` mid-frame while busy -> no extra frame; counters unchanged; current frame bit-exact.
- Assert `rst` during DATA bit 3 ->
  - `tx`=1 and counters 0 the next cycle
  - `cap_ready`=1 the cycle after `rst` deasserts
  - the next frame is a clean full frame
- 256 consecutive mismatches -> `fail_cnt` stops at 255 (no wrap to 0); `pass_cnt` stays 0.
